// File: rtl/prog_loader.sv
// prog_loader: streams encoded instructions into an instruction memory.
//
// A start pulse opens a load session at address 0. Each accepted request is
// encoded into a 24-bit word and written one cycle later. The session ends on
// in_last or when the memory is full; a halt word (24'h000000) is then written
// at the current pointer, and done pulses.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               single-cycle pulse, opens a session (from IDLE/DONE)
//   in_valid/in_ready   request handshake
//   in_last             request is the final instruction
//   in_class, in_alu    opcode[3:0], opcode[5:4]
//   in_rd/in_rs/in_rt   register indices
//   in_imm              signed immediate / branch offset
//   im_wen/im_addr/im_wdata  instruction-memory write port
//   busy, done, err, count   status
//
// Optional feature: define PROG_LOADER_IMM_CHECK_EN to reject immediate/branch
// requests whose in_imm does not fit in 10 signed bits.
module prog_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_class,
  input  logic [1:0]        in_alu,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs,
  input  logic [3:0]        in_rt,
  input  logic [15:0]       in_imm,
  output logic              im_wen,
  output logic [ADDR_W-1:0] im_addr,
  output logic [23:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       wdata_q, wdata_d;

  logic [5:0]  opcode;
  logic        is_rtype, is_branch, illegal, accept;
  logic [23:0] word;

  assign opcode  = {in_alu, in_class};
  assign ptr_inc = ptr_q + ADDR_W'(1);

  // Instruction encoding
  always_comb begin
    is_rtype  = ~in_class[3];
    is_branch = (in_class[3:1] == 3'b110);
    if (is_rtype) begin
      word = {opcode, in_rd, in_rs, in_rt, 6'b000000};
    end else if (is_branch) begin
      word = {opcode, in_rs, in_rt, in_imm[9:0]};
    end else begin
      word = {opcode, in_rd, in_rs, in_imm[9:0]};
    end
  end

`ifdef PROG_LOADER_IMM_CHECK_EN
  logic imm_class, imm_fits;
  // Classes 8..13 carry an immediate/offset; it fits if bits [15:9] all agree.
  assign imm_class = in_class[3] & (in_class[3:1] != 3'b111);
  assign imm_fits  = (in_imm[15:9] == 7'h00) || (in_imm[15:9] == 7'h7f);
  assign illegal   = (opcode == 6'b000000) || (imm_class && !imm_fits);
`else
  logic unused_imm;
  assign unused_imm = ^in_imm[15:10];
  assign illegal    = (opcode == 6'b000000);
`endif

  // The last address is reserved for the halt word.
  assign in_ready = (state_q == StLoad) && (ptr_q != LastAddr);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    done_d  = 1'b0;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLoad;
          ptr_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      StLoad: begin
        if (accept) begin
          if (illegal) begin
            err_d = 1'b1;
            if (in_last) state_d = StFlush;
          end else begin
            wen_d   = 1'b1;
            addr_d  = ptr_q;
            wdata_d = word;
            ptr_d   = ptr_inc;
            count_d = count_q + (ADDR_W + 1)'(1);
            if (in_last) begin
              state_d = StFlush;
            end else if (ptr_inc == LastAddr) begin
              // Memory full without a final instruction.
              err_d   = 1'b1;
              state_d = StFlush;
            end
          end
        end
      end
      StFlush: begin
        wen_d   = 1'b1;
        addr_d  = ptr_q;
        wdata_d = 24'h000000;
        count_d = count_q + (ADDR_W + 1)'(1);
        done_d  = 1'b1;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      done_q  <= done_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign im_wen   = wen_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign busy     = (state_q == StLoad) || (state_q == StFlush);
  assign done     = done_q;
  assign err      = err_q;
  assign count    = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: one instance with ADDR_W=8 (a) and one with ADDR_W=2 (b).
// Expected writes are queued per instance; a negedge monitor pops and compares.
module tb_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_n_b, start_a, start_b, in_valid_a, in_valid_b, in_last;
  logic [3:0]  in_class, in_rd, in_rs, in_rt;
  logic [1:0]  in_alu;
  logic [15:0] in_imm;

  logic        in_ready_a, im_wen_a, busy_a, done_a, err_a;
  logic [7:0]  im_addr_a;
  logic [23:0] im_wdata_a;
  logic [8:0]  count_a;

  logic        in_ready_b, im_wen_b, busy_b, done_b, err_b;
  logic [1:0]  im_addr_b;
  logic [23:0] im_wdata_b;
  logic [2:0]  count_b;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  prog_loader #(.ADDR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_last(in_last), .in_class(in_class), .in_alu(in_alu), .in_rd(in_rd), .in_rs(in_rs),
    .in_rt(in_rt), .in_imm(in_imm), .im_wen(im_wen_a), .im_addr(im_addr_a),
    .im_wdata(im_wdata_a), .busy(busy_a), .done(done_a), .err(err_a), .count(count_a)
  );

  prog_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_last(in_last), .in_class(in_class), .in_alu(in_alu), .in_rd(in_rd), .in_rs(in_rs),
    .in_rt(in_rt), .in_imm(in_imm), .im_wen(im_wen_b), .im_addr(im_addr_b),
    .im_wdata(im_wdata_b), .busy(busy_b), .done(done_b), .err(err_b), .count(count_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (im_wen_a === 1'b1) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL write_a_unexpected: got %h@%h expected no write", im_wdata_a, im_addr_a);
      end else begin
        check("write_a", {im_addr_a, im_wdata_a}, q_a.pop_front());
      end
    end
    if (im_wen_b === 1'b1) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL write_b_unexpected: got %h@%h expected no write", im_wdata_b, im_addr_b);
      end else begin
        check("write_b", {6'b0, im_addr_b, im_wdata_b}, q_b.pop_front());
      end
    end
  end

  task automatic send(input bit sel, input logic [3:0] cls, input logic [1:0] alu,
                      input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                      input logic [15:0] imm, input bit last, input bit exp_wen);
    int n;
    @(negedge clk);
    in_class = cls; in_alu = alu; in_rd = rd; in_rs = rs; in_rt = rt;
    in_imm = imm; in_last = last;
    if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    n = 0;
    while (((sel ? in_ready_b : in_ready_a) !== 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      fail_now("handshake");
      in_valid_a = 1'b0; in_valid_b = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_last = 1'b0;
    check("wen_latency", 32'(sel ? im_wen_b : im_wen_a), 32'(exp_wen));
  endtask

  task automatic wait_done(input bit sel, input int exp_count);
    int n;
    n = 0;
    while (((sel ? done_b : done_a) !== 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      fail_now("done_wait");
      return;
    end
    check("count_at_done", sel ? 32'(count_b) : 32'(count_a), 32'(exp_count));
    @(negedge clk);
    check("done_pulse_busy", sel ? {done_b, busy_b} : {done_a, busy_a}, 32'd0);
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [23:0] b_words [3];
    int ptr;
    b_words[0] = 24'h044000;
    b_words[1] = 24'h048000;
    b_words[2] = 24'h04C000;

    rst_n = 1'b0; rst_n_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_last = 1'b0;
    in_class = '0; in_alu = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_imm = '0;
    #12;
    check("reset_ctl_a", {in_ready_a, im_wen_a, busy_a, done_a, err_a, count_a, im_addr_a}, 32'd0);
    check("reset_wdata_a", {8'd0, im_wdata_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; rst_n_b = 1'b1;

    // Session 1: immediate, range case, branch, illegal last
    pulse_start(1'b0);
    check("start_busy_ready", {busy_a, in_ready_a}, 32'd3);
    ptr = 0;
    q_a.push_back({8'(ptr), 24'h60CBFB}); ptr++;
    send(1'b0, 4'd8, 2'd1, 4'd3, 4'd2, 4'd0, 16'hFFFB, 1'b0, 1'b1);
`ifdef PROG_LOADER_IMM_CHECK_EN
    send(1'b0, 4'd9, 2'd0, 4'd1, 4'd1, 4'd0, 16'd600, 1'b0, 1'b0);
    check("imm_range_err", 32'(err_a), 32'd1);
`else
    q_a.push_back({8'(ptr), 24'h244658}); ptr++;
    send(1'b0, 4'd9, 2'd0, 4'd1, 4'd1, 4'd0, 16'd600, 1'b0, 1'b1);
    check("imm_trunc_no_err", 32'(err_a), 32'd0);
`endif
    q_a.push_back({8'(ptr), 24'h319C03}); ptr++;
    send(1'b0, 4'd12, 2'd0, 4'd0, 4'd6, 4'd7, 16'd3, 1'b0, 1'b1);
    q_a.push_back({8'(ptr), 24'h000000});
    send(1'b0, 4'd0, 2'd0, 4'd1, 4'd1, 4'd1, 16'd0, 1'b1, 1'b0);
    check("illegal_err", 32'(err_a), 32'd1);
    wait_done(1'b0, ptr + 1);

    // Session 2: restart from DONE, R-type with last
    pulse_start(1'b0);
    check("restart_clears", {err_a, count_a}, 32'd0);
    q_a.push_back({8'd0, 24'h885140});
    q_a.push_back({8'd1, 24'h000000});
    send(1'b0, 4'd2, 2'd2, 4'd1, 4'd4, 4'd5, 16'd0, 1'b1, 1'b1);
    wait_done(1'b0, 2);
    check("err_clean_session", 32'(err_a), 32'd0);

    // Capacity overflow on ADDR_W=2
    pulse_start(1'b1);
    for (int i = 0; i < 3; i++) q_b.push_back({6'b0, 2'(i), b_words[i]});
    q_b.push_back({6'b0, 2'd3, 24'h000000});
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 4'd1, 2'd0, 4'(i + 1), 4'd0, 4'd0, 16'd0, 1'b0, 1'b1);
    end
    check("full_ready_low", 32'(in_ready_b), 32'd0);
    in_valid_b = 1'b1;
    wait_done(1'b1, 4);
    check("full_err", 32'(err_b), 32'd1);
    repeat (3) @(negedge clk);
    check("done_ready_low", 32'(in_ready_b), 32'd0);
    in_valid_b = 1'b0;

    // Reset while a write is being presented
    pulse_start(1'b1);
    @(negedge clk);
    in_class = 4'd1; in_alu = 2'd0; in_rd = 4'd1; in_rs = 4'd0; in_rt = 4'd0;
    in_valid_b = 1'b1;
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    check("pre_reset_wen", 32'(im_wen_b), 32'd1);
    rst_n_b = 1'b0;
    #1;
    check("async_reset_ctl_b",
          {in_ready_b, im_wen_b, busy_b, done_b, err_b, count_b, im_addr_b}, 32'd0);
    check("async_reset_wdata_b", {8'd0, im_wdata_b}, 32'd0);
    @(negedge clk);
    rst_n_b = 1'b1;

    repeat (3) @(negedge clk);
    check("queue_a_empty", 32'(q_a.size()), 32'd0);
    check("queue_b_empty", 32'(q_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
